// File: rtl/isram_resp.sv
// isram_resp: instruction SRAM responder with a fetch read port and a starvation-protected loader write port
// Ports: clk/cpurst (async active-high) | isram_cs, isram_adr -> instr_fromsram, isram_rvalid, isram_err (1-cycle latency)
//        isram_busy: forced loader-write cycle, fetch stalls | ld_valid, ld_adr, ld_data -> ld_ready (combinational)
module isram_resp #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          DEPTH_LOG2   = 10,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        isram_cs,
  input  logic [31:3] isram_adr,
  output logic [63:0] instr_fromsram,
  output logic        isram_rvalid,
  output logic        isram_err,
  output logic        isram_busy,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:2] ld_adr,
  input  logic [31:0] ld_data
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int RB = DEPTH_LOG2 + 3;
  // Halves kept in separate arrays so a 32-bit loader write never needs a read-modify-write
  logic [31:0] lo_q [2**DEPTH_LOG2];
  logic [31:0] hi_q [2**DEPTH_LOG2];
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, rvalid_q, err_q;
  logic [63:0] data_q;
  logic rd_acc, rd_in, wr_acc, wr_in, starve;
  logic [DEPTH_LOG2-1:0] ridx, widx;
  always_comb begin
    ld_ready = !isram_cs | busy_q;
    rd_acc   = isram_cs & !busy_q;
    wr_acc   = ld_valid & ld_ready;
    starve   = ld_valid & !ld_ready;
    rd_in    = isram_adr[31:RB] == BASE_ADDR[31:RB];
    wr_in    = ld_adr[31:RB] == BASE_ADDR[31:RB];
    ridx     = isram_adr[RB-1:3];
    widx     = ld_adr[RB-1:3];
    cnt_d    = starve ? cnt_q + 1'b1 : '0;
    // busy lasts one cycle: during it ld_ready=1, so starve is 0 and busy_d clears
    busy_d   = starve && cnt_q == CW'(STARVE_LIMIT - 1);
  end
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        data_q <= rd_in ? {hi_q[ridx], lo_q[ridx]} : '0;
        err_q  <= !rd_in;
      end
    end
  end
  // Array is not reset; out-of-range writes are accepted but dropped here
  always_ff @(posedge clk) begin
    if (wr_acc && wr_in && ld_adr[2]) hi_q[widx] <= ld_data;
    if (wr_acc && wr_in && !ld_adr[2]) lo_q[widx] <= ld_data;
  end
  assign instr_fromsram = data_q;
  assign isram_rvalid   = rvalid_q;
  assign isram_err      = err_q;
  assign isram_busy     = busy_q;
endmodule
